mem_arbiter: RTL and testbench

Shares a single variable-latency memory port (Rd/Wr/Done protocol, as used by the DRAMStall and mem_system models) between the core's instruction-fetch port and data port. It is used in unified-memory builds where instruction and data memory are one physical array. Data requests have priority, and a bounded streak counter guarantees fetch progress. Each requester sees the same request/done handshake the core already uses toward separate memories.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency Rd/Wr/Done memory port between the
// instruction-fetch port and the data port. Data has priority, and a saturating
// streak counter bounds how long a pending fetch can be held off.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_i_req,
  input  logic [31:0] i_i_addr,
  output logic        o_i_done,
  output logic [31:0] o_i_data,
  input  logic        i_d_req,
  input  logic        i_d_wr,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic        o_d_done,
  output logic [31:0] o_d_data,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_din,
  input  logic        i_mem_done,
  input  logic [31:0] i_mem_dout,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  state_t      state;
  logic        owner_d;   // 1 = data port owns the transaction, 0 = fetch
  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] i_data_q;
  logic [31:0] d_data_q;
  logic [3:0]  streak;
  logic        i_done_q;
  logic        d_done_q;

  logic arb_en;
  logic at_limit;
  logic grant_d;
  logic grant_i;

  // Arbitration: data wins a tie unless it has used up its streak allowance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    arb_en   = 1'b0;
    at_limit = 1'b0;
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    arb_en   = (state != BUSY);
    at_limit = (streak == STREAK_MAX);
    grant_d  = arb_en && i_d_req && !(i_i_req && at_limit);
    grant_i  = arb_en && i_i_req && !grant_d;
  end

  // Transaction FSM, request capture, streak counter and registered done/data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      state    <= IDLE;
      owner_d  <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      i_data_q <= '0;
      d_data_q <= '0;
      streak   <= '0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant_d || grant_i) begin
            owner_d <= grant_d;
            addr_q  <= grant_d ? i_d_addr : i_i_addr;
            wr_q    <= grant_d && i_d_wr;
            wdata_q <= grant_d ? i_d_wdata : '0;
            state   <= BUSY;
            if (grant_i || !i_i_req) begin
              streak <= '0;
            end else if (!at_limit) begin
              streak <= streak + 4'd1;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (i_mem_done) begin
            if (owner_d) begin
              d_done_q <= 1'b1;
              if (!wr_q) d_data_q <= i_mem_dout;
            end else begin
              i_done_q <= 1'b1;
              i_data_q <= i_mem_dout;
            end
            state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_busy     = (state == BUSY);
  assign o_mem_rd   = o_busy && !wr_q;
  assign o_mem_wr   = o_busy && wr_q;
  assign o_mem_addr = addr_q;
  assign o_mem_din  = wdata_q;
  assign o_i_done   = i_done_q;
  assign o_d_done   = d_done_q;
  assign o_i_data   = i_data_q;
  assign o_d_data   = d_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter. dut_a uses MAX_D_STREAK=4,
// dut_b shares all inputs and uses MAX_D_STREAK=2 for the starvation bound.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        mem_done;
  logic [31:0] mem_dout;

  logic        a_i_done, a_d_done, a_mem_rd, a_mem_wr, a_busy;
  logic [31:0] a_i_data, a_d_data, a_mem_addr, a_mem_din;
  logic        b_i_done, b_d_done, b_mem_rd, b_mem_wr, b_busy;
  logic [31:0] b_i_data, b_d_data, b_mem_addr, b_mem_din;

  int n_asserts = 0;
  int n_fail    = 0;

  mem_arbiter #(.MAX_D_STREAK(4)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_done(a_i_done), .o_i_data(a_i_data),
    .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_done(a_d_done), .o_d_data(a_d_data),
    .o_mem_rd(a_mem_rd), .o_mem_wr(a_mem_wr), .o_mem_addr(a_mem_addr), .o_mem_din(a_mem_din),
    .i_mem_done(mem_done), .i_mem_dout(mem_dout), .o_busy(a_busy)
  );

  mem_arbiter #(.MAX_D_STREAK(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_i_req(i_req), .i_i_addr(i_addr), .o_i_done(b_i_done), .o_i_data(b_i_data),
    .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_done(b_d_done), .o_d_data(b_d_data),
    .o_mem_rd(b_mem_rd), .o_mem_wr(b_mem_wr), .o_mem_addr(b_mem_addr), .o_mem_din(b_mem_din),
    .i_mem_done(mem_done), .i_mem_dout(mem_dout), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Outputs that must all be zero in reset
  task automatic check_all_zero(input string tag);
    check({tag, " busy"},   {31'd0, a_busy},   32'd0);
    check({tag, " rd"},     {31'd0, a_mem_rd}, 32'd0);
    check({tag, " wr"},     {31'd0, a_mem_wr}, 32'd0);
    check({tag, " i_done"}, {31'd0, a_i_done}, 32'd0);
    check({tag, " d_done"}, {31'd0, a_d_done}, 32'd0);
    check({tag, " addr"},   a_mem_addr,        32'd0);
    check({tag, " din"},    a_mem_din,         32'd0);
    check({tag, " i_data"}, a_i_data,          32'd0);
    check({tag, " d_data"}, a_d_data,          32'd0);
  endtask

  logic       exp_d   [6];
  logic [3:0] exp_stk [6];

  initial begin
    rst_n    = 1'b0;
    i_req    = 1'b0;
    i_addr   = '0;
    d_req    = 1'b0;
    d_wr     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    mem_done = 1'b0;
    mem_dout = '0;

    // ---------------- reset state ----------------
    step();
    step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();
    check("post-reset busy", {31'd0, a_busy}, 32'd0);

    // ---------------- single fetch, memory done in cycle 3 ----------------
    i_req  = 1'b1;
    i_addr = 32'h0000_0100;                                   // cycle 0
    step();                                                   // cycle 1
    check("fetch c1 rd",   {31'd0, a_mem_rd}, 32'd1);
    check("fetch c1 wr",   {31'd0, a_mem_wr}, 32'd0);
    check("fetch c1 addr", a_mem_addr,        32'h0000_0100);
    check("fetch c1 busy", {31'd0, a_busy},   32'd1);
    step();                                                   // cycle 2
    check("fetch c2 rd",   {31'd0, a_mem_rd}, 32'd1);
    step();                                                   // cycle 3
    check("fetch c3 rd",   {31'd0, a_mem_rd}, 32'd1);
    check("fetch c3 i_done early", {31'd0, a_i_done}, 32'd0);
    mem_done = 1'b1;
    mem_dout = 32'hDEAD_BEEF;
    step();                                                   // cycle 4
    check("fetch c4 i_done", {31'd0, a_i_done}, 32'd1);
    check("fetch c4 d_done", {31'd0, a_d_done}, 32'd0);
    check("fetch c4 i_data", a_i_data,          32'hDEAD_BEEF);
    check("fetch c4 rd",     {31'd0, a_mem_rd}, 32'd0);
    check("fetch c4 busy",   {31'd0, a_busy},   32'd0);
    i_req    = 1'b0;
    mem_done = 1'b0;
    step();                                                   // cycle 5
    check("fetch idle busy",   {31'd0, a_busy},   32'd0);
    check("fetch idle i_done", {31'd0, a_i_done}, 32'd0);
    check("fetch idle rd",     {31'd0, a_mem_rd}, 32'd0);

    // ---------------- data write, latency 1 ----------------
    d_req   = 1'b1;
    d_wr    = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = 32'h1234_5678;
    step();
    check("write wr",   {31'd0, a_mem_wr}, 32'd1);
    check("write rd",   {31'd0, a_mem_rd}, 32'd0);
    check("write din",  a_mem_din,         32'h1234_5678);
    check("write addr", a_mem_addr,        32'h0000_2000);
    mem_done = 1'b1;
    mem_dout = 32'hAAAA_5555;
    step();
    check("write d_done", {31'd0, a_d_done}, 32'd1);
    check("write i_done", {31'd0, a_i_done}, 32'd0);
    check("write d_data unchanged", a_d_data, 32'd0);
    check("write wr low in RESP", {31'd0, a_mem_wr}, 32'd0);
    d_req    = 1'b0;
    d_wr     = 1'b0;
    mem_done = 1'b0;
    step();
    check("write single pulse", {31'd0, a_d_done}, 32'd0);
    check("write wr idle",      {31'd0, a_mem_wr}, 32'd0);

    // ---------------- simultaneous requests ----------------
    i_req  = 1'b1;
    i_addr = 32'h0000_0300;
    d_req  = 1'b1;
    d_addr = 32'h0000_0400;
    step();
    check("simul first addr", a_mem_addr,        32'h0000_0400);
    check("simul first rd",   {31'd0, a_mem_rd}, 32'd1);
    mem_done = 1'b1;
    mem_dout = 32'h1111_1111;
    step();
    check("simul d_done", {31'd0, a_d_done}, 32'd1);
    check("simul no i_done", {31'd0, a_i_done}, 32'd0);
    check("simul d_data", a_d_data, 32'h1111_1111);
    d_req    = 1'b0;
    mem_done = 1'b0;
    step();
    check("simul second addr", a_mem_addr,        32'h0000_0300);
    check("simul second rd",   {31'd0, a_mem_rd}, 32'd1);
    mem_done = 1'b1;
    mem_dout = 32'h2222_2222;
    step();
    check("simul i_done", {31'd0, a_i_done}, 32'd1);
    check("simul no d_done", {31'd0, a_d_done}, 32'd0);
    check("simul i_data", a_i_data, 32'h2222_2222);
    i_req    = 1'b0;
    mem_done = 1'b0;
    step();
    check("simul idle", {31'd0, a_busy}, 32'd0);

    // ---------------- mid-transaction changes, spurious mem done ----------------
    d_req  = 1'b1;
    d_addr = 32'h0000_0500;
    step();
    check("mid latched addr", a_mem_addr, 32'h0000_0500);
    d_addr = 32'h0000_05FC;
    d_req  = 1'b0;
    step();
    check("mid addr hold 1", a_mem_addr,        32'h0000_0500);
    check("mid busy 1",      {31'd0, a_busy},   32'd1);
    check("mid rd 1",        {31'd0, a_mem_rd}, 32'd1);
    check("mid no d_done 1", {31'd0, a_d_done}, 32'd0);
    d_req = 1'b1;
    step();
    check("mid addr hold 2", a_mem_addr,      32'h0000_0500);
    check("mid busy 2",      {31'd0, a_busy}, 32'd1);
    d_req    = 1'b0;
    mem_done = 1'b1;
    mem_dout = 32'h3333_3333;
    step();
    check("mid d_done", {31'd0, a_d_done}, 32'd1);
    check("mid d_data", a_d_data,          32'h3333_3333);
    mem_done = 1'b0;
    step();
    check("mid idle", {31'd0, a_busy}, 32'd0);
    mem_done = 1'b1;                                           // spurious, in IDLE
    mem_dout = 32'h9999_9999;
    step();
    check("spurious busy",   {31'd0, a_busy},   32'd0);
    check("spurious i_done", {31'd0, a_i_done}, 32'd0);
    check("spurious d_done", {31'd0, a_d_done}, 32'd0);
    check("spurious rd",     {31'd0, a_mem_rd}, 32'd0);
    mem_done = 1'b0;
    step();
    check("spurious after i_done", {31'd0, a_i_done}, 32'd0);
    check("spurious after d_done", {31'd0, a_d_done}, 32'd0);
    check("spurious d_data kept",  a_d_data,          32'h3333_3333);

    // ---------------- reset during BUSY ----------------
    i_req  = 1'b1;
    i_addr = 32'h0000_0600;
    step();
    check("rst pre busy", {31'd0, a_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    mem_done = 1'b1;
    mem_dout = 32'h4444_4444;
    step();
    check("rst no i_done", {31'd0, a_i_done}, 32'd0);
    check("rst i_data",    a_i_data,          32'd0);
    check("rst busy",      {31'd0, a_busy},   32'd0);
    i_req    = 1'b0;
    mem_done = 1'b0;
    rst_n    = 1'b1;
    step();
    check("rst released idle", {31'd0, a_busy}, 32'd0);
    i_req  = 1'b1;
    i_addr = 32'h0000_0700;
    step();
    check("rst new rd",   {31'd0, a_mem_rd}, 32'd1);
    check("rst new addr", a_mem_addr,        32'h0000_0700);
    mem_done = 1'b1;
    mem_dout = 32'h5555_5555;
    step();
    check("rst new i_done", {31'd0, a_i_done}, 32'd1);
    check("rst new i_data", a_i_data,          32'h5555_5555);
    i_req    = 1'b0;
    mem_done = 1'b0;
    step();
    check("rst new idle", {31'd0, a_busy}, 32'd0);

    // ---------------- starvation bound on dut_b (MAX_D_STREAK=2) ----------------
    exp_d[0] = 1'b1; exp_stk[0] = 4'd1;
    exp_d[1] = 1'b1; exp_stk[1] = 4'd2;
    exp_d[2] = 1'b0; exp_stk[2] = 4'd0;
    exp_d[3] = 1'b1; exp_stk[3] = 4'd1;
    exp_d[4] = 1'b1; exp_stk[4] = 4'd2;
    exp_d[5] = 1'b0; exp_stk[5] = 4'd0;
    i_req  = 1'b1;
    i_addr = 32'h0000_0800;
    d_req  = 1'b1;
    d_wr   = 1'b0;
    d_addr = 32'h0000_0900;
    for (int t = 0; t < 6; t++) begin
      step();                                                  // BUSY
      check($sformatf("starve %0d busy", t), {31'd0, b_busy}, 32'd1);
      check($sformatf("starve %0d owner addr", t), b_mem_addr,
            exp_d[t] ? 32'h0000_0900 : 32'h0000_0800);
      check($sformatf("starve %0d streak", t), {28'd0, dut_b.streak}, {28'd0, exp_stk[t]});
      mem_done = 1'b1;
      mem_dout = 32'hC0DE_0000 + 32'(t);
      step();                                                  // RESP
      check($sformatf("starve %0d d_done", t), {31'd0, b_d_done}, {31'd0, exp_d[t]});
      check($sformatf("starve %0d i_done", t), {31'd0, b_i_done}, {31'd0, !exp_d[t]});
      if (exp_d[t])
        check($sformatf("starve %0d d_data", t), b_d_data, 32'hC0DE_0000 + 32'(t));
      else
        check($sformatf("starve %0d i_data", t), b_i_data, 32'hC0DE_0000 + 32'(t));
      mem_done = 1'b0;
      if (t == 5) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    step();
    check("starve idle", {31'd0, b_busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
